// File: rtl/csa_pkg.sv
// Shared definitions for the pipelined carry-select adder.
//   DEF_WIDTH / DEF_BLK : default operand width and carry-select block width
//   calc_nblk()         : number of carry-select blocks, i.e. pipeline stages
package csa_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_BLK   = 4;

    // WIDTH is required to be an exact multiple of BLK.
    function automatic int unsigned calc_nblk(input int unsigned width,
                                              input int unsigned blk);
        return width / blk;
    endfunction

endpackage

// File: rtl/csa_block.sv
// One carry-select slice: ripples the block twice (carry-in 0 and 1) and
// picks the pair of results with the real incoming carry.
//   i_a, i_b : BLK-bit operand slices
//   i_cin    : incoming carry that selects between the two precomputed sums
//   o_sum    : selected BLK-bit sum
//   o_cout   : selected carry out of the block MSB
//   o_c_msb  : selected carry into the block MSB (used for signed overflow)
module csa_block
    import csa_pkg::*;
#(
    parameter int unsigned BLK = DEF_BLK
) (
    input  logic [BLK-1:0] i_a,
    input  logic [BLK-1:0] i_b,
    input  logic           i_cin,
    output logic [BLK-1:0] o_sum,
    output logic           o_cout,
    output logic           o_c_msb
);

    logic [BLK:0]   w_c0;
    logic [BLK:0]   w_c1;
    logic [BLK-1:0] w_s0;
    logic [BLK-1:0] w_s1;

    // Two independent ripple chains, one per assumed carry-in.
    always_comb begin
        w_c0 = '0;
        w_c1 = '0;
        w_s0 = '0;
        w_s1 = '0;
        w_c0[0] = 1'b0;
        w_c1[0] = 1'b1;
        for (int i = 0; i < int'(BLK); i++) begin
            w_s0[i]   = i_a[i] ^ i_b[i] ^ w_c0[i];
            w_c0[i+1] = (i_a[i] & i_b[i]) | (w_c0[i] & (i_a[i] ^ i_b[i]));
            w_s1[i]   = i_a[i] ^ i_b[i] ^ w_c1[i];
            w_c1[i+1] = (i_a[i] & i_b[i]) | (w_c1[i] & (i_a[i] ^ i_b[i]));
        end
    end

    // Late-arriving carry only drives the select muxes.
    assign o_sum   = i_cin ? w_s1 : w_s0;
    assign o_cout  = i_cin ? w_c1[BLK] : w_c0[BLK];
    assign o_c_msb = i_cin ? w_c1[BLK-1] : w_c0[BLK-1];

endmodule

// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder/subtractor with valid/ready handshakes.
// One carry-select block is resolved per stage, so a result appears NBLK
// cycles after accept; a single global enable stalls the whole pipe.
//   i_clk, i_rst_n            : clock, async active-low reset
//   i_valid / o_ready         : operand handshake
//   i_add_term1, i_add_term2  : operands A and B
//   i_cin, i_sub              : carry-in (add only), subtract select
//   o_valid / i_ready         : result handshake
//   sum, cout, o_ovf          : registered result, carry out, signed overflow
module csa_pipe_adder
    import csa_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned BLK   = DEF_BLK
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_add_term1,
    input  logic [WIDTH-1:0] i_add_term2,
    input  logic             i_cin,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             o_ovf
);

    localparam int unsigned NBLK = calc_nblk(WIDTH, BLK);

    // Per-stage state: operands (upper bits still pending), partial sum,
    // block carry out and valid.
    logic [WIDTH-1:0] r_a   [NBLK];
    logic [WIDTH-1:0] r_b   [NBLK];
    logic [WIDTH-1:0] r_sum [NBLK];
    logic             r_c   [NBLK];
    logic             r_v   [NBLK];
    logic             r_ovf;

    logic [BLK-1:0]   w_blk_a    [NBLK];
    logic [BLK-1:0]   w_blk_b    [NBLK];
    logic [BLK-1:0]   w_blk_sum  [NBLK];
    logic             w_blk_cin  [NBLK];
    logic             w_blk_cout [NBLK];
    logic             w_blk_cmsb [NBLK];

    logic             w_adv;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;

    // Subtraction is A + ~B + 1; i_cin is ignored then.
    assign w_b_eff   = i_sub ? ~i_add_term2 : i_add_term2;
    assign w_cin_eff = i_sub | i_cin;

    // Stall only when a finished result is waiting on downstream.
    assign w_adv   = ~r_v[NBLK-1] | i_ready;
    assign o_ready = w_adv;

    genvar g;
    generate
        for (g = 0; g < int'(NBLK); g++) begin : g_stage
            if (g == 0) begin : g_first
                assign w_blk_a[g]   = i_add_term1[BLK-1:0];
                assign w_blk_b[g]   = w_b_eff[BLK-1:0];
                assign w_blk_cin[g] = w_cin_eff;
            end else begin : g_rest
                assign w_blk_a[g]   = r_a[g-1][g*BLK +: BLK];
                assign w_blk_b[g]   = r_b[g-1][g*BLK +: BLK];
                assign w_blk_cin[g] = r_c[g-1];
            end

            csa_block #(
                .BLK (BLK)
            ) u_blk (
                .i_a     (w_blk_a[g]),
                .i_b     (w_blk_b[g]),
                .i_cin   (w_blk_cin[g]),
                .o_sum   (w_blk_sum[g]),
                .o_cout  (w_blk_cout[g]),
                .o_c_msb (w_blk_cmsb[g])
            );
        end
    endgenerate

    // Pipeline registers; everything moves together on w_adv.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < int'(NBLK); s++) begin
                r_a[s]   <= '0;
                r_b[s]   <= '0;
                r_sum[s] <= '0;
                r_c[s]   <= 1'b0;
                r_v[s]   <= 1'b0;
            end
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            r_a[0]   <= i_add_term1;
            r_b[0]   <= w_b_eff;
            r_sum[0] <= WIDTH'(w_blk_sum[0]);
            r_c[0]   <= w_blk_cout[0];
            r_v[0]   <= i_valid;
            for (int s = 1; s < int'(NBLK); s++) begin
                r_a[s]                 <= r_a[s-1];
                r_b[s]                 <= r_b[s-1];
                r_sum[s]               <= r_sum[s-1];
                r_sum[s][s*BLK +: BLK] <= w_blk_sum[s];
                r_c[s]                 <= w_blk_cout[s];
                r_v[s]                 <= r_v[s-1];
            end
            r_ovf <= w_blk_cmsb[NBLK-1] ^ w_blk_cout[NBLK-1];
        end
    end

    assign o_valid = r_v[NBLK-1];
    assign sum     = r_sum[NBLK-1];
    assign cout    = r_c[NBLK-1];
    assign o_ovf   = r_ovf;

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Self-checking bench for csa_pipe_adder (WIDTH=16, BLK=4): directed vectors,
// stall/ordering, mid-flight reset and a random valid/ready soak, all checked
// through an expected-result queue.
module tb_csa_pipe_adder;

    localparam int unsigned W    = 16;
    localparam int unsigned NBLK = 4;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin_in;
    logic         sub_in;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         o_ovf;

    int   errors = 0;
    int   checks = 0;
    res_t sb[$];
    logic rnd_rdy = 1'b0;

    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_sum;
    logic         prev_cout;
    logic         prev_ovf;

    always #5 clk = ~clk;

    csa_pipe_adder #(
        .WIDTH (16),
        .BLK   (4)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_add_term1 (a_in),
        .i_add_term2 (b_in),
        .i_cin       (cin_in),
        .i_sub       (sub_in),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .sum         (sum),
        .cout        (cout),
        .o_ovf       (o_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci, input logic su);
        logic [W-1:0] be;
        logic         c0;
        logic [W:0]   t;
        res_t         r;
        be  = su ? ~b : b;
        c0  = su ? 1'b1 : ci;
        t   = {1'b0, a} + {1'b0, be} + (W+1)'(c0);
        r.s = t[W-1:0];
        r.c = t[W];
        r.v = (a[W-1] == be[W-1]) && (t[W-1] != a[W-1]);
        return r;
    endfunction

    // Drive one operand set; wait (bounded) for acceptance, then queue expected result.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic su, input res_t exp);
        int   n;
        logic acc;
        n       = 0;
        acc     = 1'b0;
        a_in    = a;
        b_in    = b;
        cin_in  = ci;
        sub_in  = su;
        i_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = o_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        i_valid = 1'b0;
        if (acc) sb.push_back(exp);
        else     chk("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic send_rnd();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic         su;
        a  = W'($urandom);
        b  = W'($urandom);
        ci = 1'($urandom);
        su = 1'($urandom);
        send(a, b, ci, su, model(a, b, ci, su));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    // Random downstream back-pressure for the soak phase.
    always @(posedge clk) begin
        #1;
        if (rnd_rdy) i_ready = ($urandom_range(3) != 0);
    end

    // Output monitor: handshake check, hold-while-stalled check, scoreboard pop.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            chk("o_ready", 32'(o_ready), 32'(!o_valid || i_ready));
            if (prev_stall) begin
                chk("hold_valid", 32'(o_valid), 32'd1);
                chk("hold_sum", 32'(sum), 32'(prev_sum));
                chk("hold_cout", 32'(cout), 32'(prev_cout));
                chk("hold_ovf", 32'(o_ovf), 32'(prev_ovf));
            end
            if (o_valid && i_ready) begin
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_result: observed sum=%0h expected no result", sum);
                end
                if (sb.size() != 0) begin
                    res_t e;
                    e = sb.pop_front();
                    chk("sum", 32'(sum), 32'(e.s));
                    chk("cout", 32'(cout), 32'(e.c));
                    chk("ovf", 32'(o_ovf), 32'(e.v));
                end
            end
            prev_stall <= o_valid && !i_ready;
            prev_sum   <= sum;
            prev_cout  <= cout;
            prev_ovf   <= o_ovf;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cnt;
        res_t e;

        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        a_in    = '0;
        b_in    = '0;
        cin_in  = 1'b0;
        sub_in  = 1'b0;
        #2;
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_o_ready", 32'(o_ready), 32'd1);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(o_ovf), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic add and latency from accept to o_valid.
        e = '{s: 16'h5555, c: 1'b0, v: 1'b0};
        send(16'h1234, 16'h4321, 1'b0, 1'b0, e);
        cnt = 1;
        while (!o_valid && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("latency", 32'(cnt), 32'(NBLK));
        drain();

        // Boundary vectors: full ripple, signed overflow, subtract with borrow.
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, '{s: 16'h0000, c: 1'b1, v: 1'b0});
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, '{s: 16'h8000, c: 1'b0, v: 1'b1});
        send(16'h0005, 16'h0007, 1'b1, 1'b1, '{s: 16'hFFFE, c: 1'b0, v: 1'b0});
        send(16'h8000, 16'h0001, 1'b0, 1'b1, '{s: 16'h7FFF, c: 1'b1, v: 1'b1});
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, '{s: 16'hFFFF, c: 1'b1, v: 1'b0});
        send(16'h0FFF, 16'h0000, 1'b1, 1'b0, '{s: 16'h1000, c: 1'b0, v: 1'b0});
        drain();

        // Eight back-to-back operands with a three-cycle downstream stall.
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    logic [W-1:0] a;
                    logic [W-1:0] b;
                    a = W'(16'h1111 * (k + 1));
                    b = W'(16'h0F0F + k);
                    send(a, b, k[0], k[1], model(a, b, k[0], k[1]));
                end
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                i_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                i_ready = 1'b1;
            end
        join
        drain();

        // Reset with three operations in flight.
        send(16'h0001, 16'h0002, 1'b0, 1'b0, model(16'h0001, 16'h0002, 1'b0, 1'b0));
        send(16'h0003, 16'h0004, 1'b0, 1'b0, model(16'h0003, 16'h0004, 1'b0, 1'b0));
        send(16'h0005, 16'h0006, 1'b0, 1'b0, model(16'h0005, 16'h0006, 1'b0, 1'b0));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_o_valid", 32'(o_valid), 32'd0);
        chk("midrst_o_ready", 32'(o_ready), 32'd1);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_cout", 32'(cout), 32'd0);
        chk("midrst_ovf", 32'(o_ovf), 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("post_rst_no_valid", 32'(o_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send(16'hABCD, 16'h1111, 1'b0, 1'b0, '{s: 16'hBCDE, c: 1'b0, v: 1'b0});
        drain();

        // Random soak with random input gaps and downstream back-pressure.
        rnd_rdy = 1'b1;
        for (int k = 0; k < 10000; k++) begin
            if ($urandom_range(3) == 0) begin
                @(posedge clk);
                #1;
            end
            send_rnd();
        end
        rnd_rdy = 1'b0;
        @(posedge clk);
        #1;
        i_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
